seg_display_mux: RTL



---
 rtl/seg_display_mux_pkg.sv | 52 +++++
 rtl/seg_symbol_decode.sv | 37 +++
 rtl/seg_display_mux.sv | 105 ++++++++++
 3 files changed

// File: rtl/seg_display_mux_pkg.sv
// Symbol codes and active-high segment patterns {a,b,c,d,e,f,g} for the front-panel display.
package seg_display_pkg;

  localparam int SYM_W = 5;

  localparam logic [SYM_W-1:0] SYM_BLANK = 5'd0;
  localparam logic [SYM_W-1:0] SYM_HEX0  = 5'd1;
  localparam logic [SYM_W-1:0] SYM_HEX1  = 5'd2;
  localparam logic [SYM_W-1:0] SYM_HEX2  = 5'd3;
  localparam logic [SYM_W-1:0] SYM_HEX3  = 5'd4;
  localparam logic [SYM_W-1:0] SYM_HEX4  = 5'd5;
  localparam logic [SYM_W-1:0] SYM_HEX5  = 5'd6;
  localparam logic [SYM_W-1:0] SYM_HEX6  = 5'd7;
  localparam logic [SYM_W-1:0] SYM_HEX7  = 5'd8;
  localparam logic [SYM_W-1:0] SYM_HEX8  = 5'd9;
  localparam logic [SYM_W-1:0] SYM_HEX9  = 5'd10;
  localparam logic [SYM_W-1:0] SYM_HEXA  = 5'd11;
  localparam logic [SYM_W-1:0] SYM_HEXB  = 5'd12;
  localparam logic [SYM_W-1:0] SYM_HEXC  = 5'd13;
  localparam logic [SYM_W-1:0] SYM_HEXD  = 5'd14;
  localparam logic [SYM_W-1:0] SYM_HEXE  = 5'd15;
  localparam logic [SYM_W-1:0] SYM_HEXF  = 5'd16;
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'd17;
  localparam logic [SYM_W-1:0] SYM_L     = 5'd18;
  localparam logic [SYM_W-1:0] SYM_D     = 5'd19;
  localparam logic [SYM_W-1:0] SYM_P     = 5'd20;
  localparam logic [SYM_W-1:0] SYM_N     = 5'd21;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_HEX0  = 7'b1111110;
  localparam logic [6:0] SEG_HEX1  = 7'b0110000;
  localparam logic [6:0] SEG_HEX2  = 7'b1101101;
  localparam logic [6:0] SEG_HEX3  = 7'b1111001;
  localparam logic [6:0] SEG_HEX4  = 7'b0110011;
  localparam logic [6:0] SEG_HEX5  = 7'b1011011;
  localparam logic [6:0] SEG_HEX6  = 7'b1011111;
  localparam logic [6:0] SEG_HEX7  = 7'b1110000;
  localparam logic [6:0] SEG_HEX8  = 7'b1111111;
  localparam logic [6:0] SEG_HEX9  = 7'b1111011;
  localparam logic [6:0] SEG_HEXA  = 7'b1110111;
  localparam logic [6:0] SEG_HEXB  = 7'b0011111;
  localparam logic [6:0] SEG_HEXC  = 7'b1001110;
  localparam logic [6:0] SEG_HEXD  = 7'b0111101;
  localparam logic [6:0] SEG_HEXE  = 7'b1001111;
  localparam logic [6:0] SEG_HEXF  = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_L     = 7'b0001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_P     = 7'b1100111;
  localparam logic [6:0] SEG_N     = 7'b0010101;

endpackage

// File: rtl/seg_symbol_decode.sv
// Combinational symbol-code to active-high segment pattern decoder; unused codes are blank.
module seg_symbol_decode
  import seg_display_pkg::*;
(
  input  logic [SYM_W-1:0] code,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      SYM_HEX0: seg = SEG_HEX0;
      SYM_HEX1: seg = SEG_HEX1;
      SYM_HEX2: seg = SEG_HEX2;
      SYM_HEX3: seg = SEG_HEX3;
      SYM_HEX4: seg = SEG_HEX4;
      SYM_HEX5: seg = SEG_HEX5;
      SYM_HEX6: seg = SEG_HEX6;
      SYM_HEX7: seg = SEG_HEX7;
      SYM_HEX8: seg = SEG_HEX8;
      SYM_HEX9: seg = SEG_HEX9;
      SYM_HEXA: seg = SEG_HEXA;
      SYM_HEXB: seg = SEG_HEXB;
      SYM_HEXC: seg = SEG_HEXC;
      SYM_HEXD: seg = SEG_HEXD;
      SYM_HEXE: seg = SEG_HEXE;
      SYM_HEXF: seg = SEG_HEXF;
      SYM_DASH: seg = SEG_DASH;
      SYM_L:    seg = SEG_L;
      SYM_D:    seg = SEG_D;
      SYM_P:    seg = SEG_P;
      SYM_N:    seg = SEG_N;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed N-digit seven-segment driver with shadowed symbols, per-digit blink
// and selectable segment/anode polarity. Outputs are registered one cycle behind idx.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLINK_SCANS    = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SYM_W*NUM_DIGITS-1:0] symbols_in,
  input  logic                        load,
  input  logic                        blink_en,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic [6:0]                  seg_out,
  output logic                        scan_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SC_W-1:0]       SC_LAST  = SC_W'(BLINK_SCANS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [SYM_W*NUM_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  logic [SC_W-1:0]             scan_cnt;
  logic                        blink_phase;

  logic [SYM_W-1:0]      sel_code;
  logic [6:0]            sel_pat;
  logic [NUM_DIGITS-1:0] an_hot;
  logic                  blank_digit;
  logic [6:0]            seg_lit;
  logic                  advance;
  logic                  wrap;

  always_comb begin
    sel_code = SYM_BLANK;
    an_hot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_code  = shadow[i*SYM_W +: SYM_W];
        an_hot[i] = 1'b1;
      end
    end
  end

  seg_symbol_decode u_decode (
    .code (sel_code),
    .seg  (sel_pat)
  );

  // Blanking only kills segments; the anode keeps scanning so brightness stays even.
  assign blank_digit = blink_en & blink_phase & (|(blink_mask & an_hot));
  assign seg_lit     = blank_digit ? SEG_BLANK : sel_pat;
  assign advance     = (cnt == CNT_LAST);
  assign wrap        = advance && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      cnt         <= '0;
      idx         <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      scan_tick   <= 1'b0;
      an_out      <= AN_OFF;
      seg_out     <= SEG_OFF;
    end else begin
      if (load) shadow <= symbols_in;

      if (advance) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      scan_tick <= wrap;

      if (wrap) begin
        if (scan_cnt == SC_LAST) begin
          scan_cnt    <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end

      an_out  <= (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
      seg_out <= (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    end
  end

endmodule
